// File: rtl/alu_pkg.sv
// Shared encodings for the extended ALU: combinational op select, mult/div op
// select and the mult/div controller state.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  // Code 7 is left unassigned and behaves like MD_NONE.
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// from the latched operands and committed on the last busy cycle.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mdop,
  input  logic             start,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAXC  = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] a_q, b_q, a_nxt, b_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [2*WIDTH-1:0] res;

  // Both operands are sign- or zero-extended to 2*WIDTH, so one unsigned
  // multiply yields the correct low 2*WIDTH bits for either signedness.
  function automatic logic [2*WIDTH-1:0] mul_res(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic sgn);
    logic [2*WIDTH-1:0] xe, ye;
    xe = {{WIDTH{sgn & x[WIDTH-1]}}, x};
    ye = {{WIDTH{sgn & y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}. Working on magnitudes makes MIN / -1
  // fall out as quotient MIN, remainder 0 without a special case.
  function automatic logic [2*WIDTH-1:0] div_res(input logic [WIDTH-1:0] n,
                                                 input logic [WIDTH-1:0] d,
                                                 input logic sgn);
    logic             nneg, dneg;
    logic [WIDTH-1:0] na, da, q, r;
    nneg = sgn & n[WIDTH-1];
    dneg = sgn & d[WIDTH-1];
    na   = nneg ? -n : n;
    da   = dneg ? -d : d;
    q    = '1;
    r    = n;
    if (d != '0) begin
      q = na / da;
      r = na % da;
      if (nneg ^ dneg) q = -q;
      if (nneg)        r = -r;
    end
    return {r, q};
  endfunction

  always_comb begin
    res = '0;
    case (op_q)
      MD_MULT:  res = mul_res(a_q, b_q, 1'b1);
      MD_MULTU: res = mul_res(a_q, b_q, 1'b0);
      MD_DIV:   res = div_res(a_q, b_q, 1'b1);
      MD_DIVU:  res = div_res(a_q, b_q, 1'b0);
      default:  res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    hi_nxt    = hi;
    lo_nxt    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (mdop)
            MD_MULT, MD_MULTU: begin
              a_nxt     = a;
              b_nxt     = b;
              op_nxt    = mdop;
              cnt_nxt   = CNT_W'(MUL_CYCLES);
              state_nxt = BUSY;
            end
            MD_DIV, MD_DIVU: begin
              a_nxt     = a;
              b_nxt     = b;
              op_nxt    = mdop;
              cnt_nxt   = CNT_W'(DIV_CYCLES);
              state_nxt = BUSY;
            end
            MD_MTHI: hi_nxt = a;
            MD_MTLO: lo_nxt = a;
            default: ;
          endcase
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) begin
          {hi_nxt, lo_nxt} = res;
          cnt_nxt          = '0;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      op_q  <= op_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/ext_alu.sv
// Extended ALU: combinational integer ops plus a multi-cycle mult/div unit
// owning the HI/LO registers.
module ext_alu
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic [2:0]       MDOp,
  input  logic             start,
  output logic [WIDTH-1:0] ALUOUT,
  output logic             Overflow,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] sum, diff;
  logic             add_ovf, sub_ovf;

  assign shamt = A[SH_W-1:0];
  assign sum   = A + B;
  assign diff  = A - B;
  // Signed overflow: operands agree (add) / differ (sub) in sign and the
  // result sign differs from A.
  assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1]  != A[WIDTH-1]);
  assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    ALUOUT   = '0;
    Overflow = 1'b0;
    case (ALUOp)
      ALU_AND:  ALUOUT = A & B;
      ALU_OR:   ALUOUT = A | B;
      ALU_ADD: begin
        ALUOUT   = sum;
        Overflow = add_ovf;
      end
      ALU_SUB: begin
        ALUOUT   = diff;
        Overflow = sub_ovf;
      end
      ALU_XOR:  ALUOUT = A ^ B;
      ALU_NOR:  ALUOUT = ~(A | B);
      ALU_SLT:  ALUOUT = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: ALUOUT = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_SLL:  ALUOUT = B << shamt;
      ALU_SRL:  ALUOUT = B >> shamt;
      ALU_SRA:  ALUOUT = $signed(B) >>> shamt;
      ALU_LUI:  ALUOUT = B << (WIDTH / 2);
      default:  ALUOUT = '0;
    endcase
  end

  assign Zero = (ALUOUT == '0);

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .a     (A),
    .b     (B),
    .mdop  (MDOp),
    .start (start),
    .hi    (HI),
    .lo    (LO),
    .busy  (busy)
  );

endmodule
